// File: rtl/formacao_pkg.sv
// Shared encodings for the enemy formation: FSM states, march direction, screen constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package formacao_pkg;

    typedef enum logic [1:0] {
        MARCH   = 2'd0,
        CLEARED = 2'd1,
        INVADED = 2'd2
    } estado_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    localparam int SCREEN_W_DEF = 640;
    localparam int MARGIN_DEF   = 20;
    localparam int LIMIT_Y_DEF  = 400;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/formacao_inimigos_if.sv
// Bundle between the formation and its neighbours (game controller drives, formation answers).
// Latency: n/a (wires only).
// Backpressure: none; every signal is sampled or driven once per CLOCK_MV cycle.
//  master (controller/bullet): pausa, reiniciarJogo, bala_ativa, bala_x, bala_y out
//  slave  (formation)        : origem_x/y, vivo, acerto, acerto_idx, restantes, formacao_vazia, invasao out
interface formacao_inimigos_if
    import formacao_pkg::*;
#(
    parameter int N = 15
) ();
    logic                      pausa;
    logic                      reiniciarJogo;
    logic                      bala_ativa;
    logic [9:0]                bala_x;
    logic [9:0]                bala_y;
    logic [10:0]               origem_x;
    logic [9:0]                origem_y;
    logic [N-1:0]              vivo;
    logic                      acerto;
    logic [idx_w(N)-1:0]       acerto_idx;
    logic [$clog2(N+1)-1:0]    restantes;
    logic                      formacao_vazia;
    logic                      invasao;

    modport master (
        output pausa, reiniciarJogo, bala_ativa, bala_x, bala_y,
        input  origem_x, origem_y, vivo, acerto, acerto_idx, restantes, formacao_vazia, invasao
    );

    modport slave (
        input  pausa, reiniciarJogo, bala_ativa, bala_x, bala_y,
        output origem_x, origem_y, vivo, acerto, acerto_idx, restantes, formacao_vazia, invasao
    );
endinterface

// File: rtl/formacao_extents.sv
// Leftmost/rightmost alive column and bottom-most alive row of the formation.
// Latency: combinational.
// Backpressure: none.
//  i_vivo : alive mask, bit r*COLS+c
//  o_lc/o_rc : lowest/highest column holding any alive enemy; o_br : highest alive row index
module formacao_extents
    import formacao_pkg::*;
#(
    parameter int ROWS = 3,
    parameter int COLS = 5
) (
    input  logic [ROWS*COLS-1:0]    i_vivo,
    output logic [idx_w(COLS)-1:0]  o_lc,
    output logic [idx_w(COLS)-1:0]  o_rc,
    output logic [idx_w(ROWS)-1:0]  o_br
);
    localparam int CIW = idx_w(COLS);
    localparam int RIW = idx_w(ROWS);

    logic [COLS-1:0] w_col_any;
    logic [ROWS-1:0] w_row_any;

    always_comb begin
        w_col_any = '0;
        w_row_any = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w_col_any[c] = w_col_any[c] | i_vivo[r*COLS+c];
                w_row_any[r] = w_row_any[r] | i_vivo[r*COLS+c];
            end
        end
    end

    // Scan direction picks the priority: last write wins.
    always_comb begin
        o_lc = '0;
        o_rc = '0;
        o_br = '0;
        for (int c = COLS - 1; c >= 0; c--) if (w_col_any[c]) o_lc = CIW'(c);
        for (int c = 0; c < COLS; c++)      if (w_col_any[c]) o_rc = CIW'(c);
        for (int r = 0; r < ROWS; r++)      if (w_row_any[r]) o_br = RIW'(r);
    end
endmodule

// File: rtl/formacao_inimigos.sv
// ROWS x COLS enemy formation marching as one block: origin, direction, alive mask, hits, cadence.
// Latency: hit and move results are registered, visible the cycle after the triggering inputs.
// Backpressure: none; pausa freezes all state, reset/reiniciarJogo override everything.
//  CLOCK_MV, reset (sync, active-high) plain ports; all game signals through formacao_inimigos_if.slave
module formacao_inimigos
    import formacao_pkg::*;
#(
    parameter int ROWS        = 3,
    parameter int COLS        = 5,
    parameter int X0          = 100,
    parameter int Y0          = 50,
    parameter int SP_X        = 60,
    parameter int SP_Y        = 40,
    parameter int ENEMY_W     = 33,
    parameter int ENEMY_H     = 24,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 16,
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int MARGIN      = MARGIN_DEF,
    parameter int LIMIT_Y     = LIMIT_Y_DEF,
    parameter int BASE_PERIOD = 30,
    parameter int MIN_PERIOD  = 2,
    parameter int SPEEDUP     = 2
) (
    input logic                CLOCK_MV,
    input logic                reset,
    formacao_inimigos_if.slave bus
);
    localparam int N   = ROWS * COLS;
    localparam int IW  = idx_w(N);
    localparam int CW  = $clog2(N + 1);
    localparam int TW  = idx_w(BASE_PERIOD);
    localparam int CIW = idx_w(COLS);
    localparam int RIW = idx_w(ROWS);

    // Edge tests folded into single thresholds so each is one 12-bit signed compare.
    localparam logic signed [11:0] LIM_R = 12'(SCREEN_W - MARGIN - ENEMY_W - STEP_X);
    localparam logic signed [11:0] LIM_L = 12'(MARGIN + STEP_X);
    localparam logic        [11:0] LIM_Y = 12'(LIMIT_Y - ENEMY_H);
    localparam logic signed [11:0] EW12  = 12'(ENEMY_W);
    localparam logic signed [11:0] EH12  = 12'(ENEMY_H);

    estado_t            r_state, w_state_nx;
    logic signed [10:0] r_ox, w_ox_nx;
    logic [9:0]         r_oy, w_oy_nx;
    logic               r_dir, w_dir_nx;
    logic [TW-1:0]      r_tick, w_tick_nx;
    logic [N-1:0]       r_vivo, w_vivo_nx;
    logic [CW-1:0]      r_rest, w_rest_nx;
    logic               r_acerto, w_acerto_nx;
    logic [IW-1:0]      r_idx, w_idx_nx;

    logic [CIW-1:0]     w_lc, w_rc;
    logic [RIW-1:0]     w_br;

    // Extents come from the registered (pre-hit) mask.
    formacao_extents #(.ROWS(ROWS), .COLS(COLS)) u_extents (
        .i_vivo (r_vivo),
        .o_lc   (w_lc),
        .o_rc   (w_rc),
        .o_br   (w_br)
    );

    logic signed [11:0] w_ox12, w_oy12, w_bx, w_by, w_lc_off, w_rc_off;
    logic [11:0]        w_br_off;

    assign w_ox12   = {r_ox[10], r_ox};
    assign w_oy12   = {2'b00, r_oy};
    assign w_bx     = {2'b00, bus.bala_x};
    assign w_by     = {2'b00, bus.bala_y};
    assign w_lc_off = 12'(int'(w_lc) * SP_X);
    assign w_rc_off = 12'(int'(w_rc) * SP_X);
    assign w_br_off = 12'(int'(w_br) * SP_Y);

    // One hit-box comparator per enemy, against the pre-move origin.
    logic [N-1:0] w_match;
    for (genvar k = 0; k < N; k++) begin : g_hit
        localparam logic signed [11:0] OFF_X = 12'((k % COLS) * SP_X);
        localparam logic signed [11:0] OFF_Y = 12'((k / COLS) * SP_Y);
        logic signed [11:0] w_x0, w_y0;
        assign w_x0 = w_ox12 + OFF_X;
        assign w_y0 = w_oy12 + OFF_Y;
        assign w_match[k] = bus.bala_ativa && r_vivo[k]
                         && (w_bx >= w_x0) && (w_bx < w_x0 + EW12)
                         && (w_by >= w_y0) && (w_by < w_y0 + EH12);
    end

    logic           w_hit_any;
    logic [IW-1:0]  w_hit_idx;
    always_comb begin
        w_hit_any = |w_match;
        w_hit_idx = '0;
        for (int k = N - 1; k >= 0; k--) if (w_match[k]) w_hit_idx = IW'(k);
    end

    // Period shortens with each kill; ">=" lets a shrinking period fire immediately.
    int   w_period;
    logic w_move;
    always_comb begin
        w_period = BASE_PERIOD - SPEEDUP * (N - int'(r_rest));
        if (w_period < MIN_PERIOD) w_period = MIN_PERIOD;
        w_move = int'(r_tick) >= w_period - 1;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_ox_nx     = r_ox;
        w_oy_nx     = r_oy;
        w_dir_nx    = r_dir;
        w_tick_nx   = r_tick;
        w_vivo_nx   = r_vivo;
        w_rest_nx   = r_rest;
        w_acerto_nx = 1'b0;
        w_idx_nx    = r_idx;
        if (r_state == MARCH && !bus.pausa) begin
            w_tick_nx = w_move ? '0 : r_tick + TW'(1);
            if (w_hit_any) begin
                w_vivo_nx[w_hit_idx] = 1'b0;
                w_rest_nx            = r_rest - CW'(1);
                w_acerto_nx          = 1'b1;
                w_idx_nx             = w_hit_idx;
            end
            if (w_move) begin
                if (r_dir == DIR_RIGHT) begin
                    if (w_ox12 + w_rc_off > LIM_R) begin
                        w_oy_nx  = r_oy + 10'(STEP_Y);
                        w_dir_nx = DIR_LEFT;
                    end else begin
                        w_ox_nx = r_ox + 11'(STEP_X);
                    end
                end else begin
                    if (w_ox12 + w_lc_off < LIM_L) begin
                        w_oy_nx  = r_oy + 10'(STEP_Y);
                        w_dir_nx = DIR_RIGHT;
                    end else begin
                        w_ox_nx = r_ox - 11'(STEP_X);
                    end
                end
            end
            // Clearing takes precedence over a simultaneous invasion.
            if (w_hit_any && r_rest == CW'(1)) begin
                w_state_nx = CLEARED;
            end else if (w_move && ({2'b00, w_oy_nx} + w_br_off >= LIM_Y)) begin
                w_state_nx = INVADED;
            end
        end
    end

    always_ff @(posedge CLOCK_MV) begin
        if (reset || bus.reiniciarJogo) begin
            r_state  <= MARCH;
            r_ox     <= 11'(X0);
            r_oy     <= 10'(Y0);
            r_dir    <= DIR_RIGHT;
            r_tick   <= '0;
            r_vivo   <= '1;
            r_rest   <= CW'(N);
            r_acerto <= 1'b0;
            r_idx    <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_ox     <= w_ox_nx;
            r_oy     <= w_oy_nx;
            r_dir    <= w_dir_nx;
            r_tick   <= w_tick_nx;
            r_vivo   <= w_vivo_nx;
            r_rest   <= w_rest_nx;
            r_acerto <= w_acerto_nx;
            r_idx    <= w_idx_nx;
        end
    end

    assign bus.origem_x       = r_ox;
    assign bus.origem_y       = r_oy;
    assign bus.vivo           = r_vivo;
    assign bus.acerto         = r_acerto;
    assign bus.acerto_idx     = r_idx;
    assign bus.restantes      = r_rest;
    assign bus.formacao_vazia = (r_state == CLEARED);
    assign bus.invasao        = (r_state == INVADED);
endmodule
